// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data memory.
// Lane selection and load extension live here so RTL and tools agree on them.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sign_ext);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: return {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: return {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational access decode: window hit, alignment fault, byte enables,
// write-data lane shift and load extraction/extension.
module mem_access_align
    import mem_pkg::*;
#(
    parameter int          DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic          rd,
    input  logic          wr,
    input  logic          busy,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    input  logic [31:0]   ram_word,
    output logic [AW-1:0] word_idx,
    output logic [3:0]    be,
    output logic [31:0]   wword,
    output logic          fault,
    output logic [31:0]   rdata
);

    logic [31:0] offset;
    logic [1:0]  lane;
    logic        hit;
    logic        misalign;
    logic        legal;

    // BASE_ADDR is aligned to the window size, so the offset's low bits equal addr[1:0].
    assign offset   = addr - BASE_ADDR;
    assign lane     = offset[1:0];
    assign hit      = (offset[31:AW+2] == '0);
    assign word_idx = offset[AW+1:2];

    always_comb begin
        misalign = 1'b0;
        case (size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = lane[0];
            SZ_WORD: misalign = (lane != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign fault = (rd | wr) & ~busy & (~hit | misalign);
    assign legal = ~busy & ~fault;
    assign be    = (wr & legal) ? lane_be(size, lane) : 4'b0000;
    assign wword = wdata << {lane, 3'b000};
    assign rdata = (rd & legal) ? load_extract(ram_word, size, lane, sign_ext) : 32'h0;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte-lane RAM, clear sequencer and sticky fault latch.
// The clear walks one word per cycle so the RAM keeps a single write port.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int          DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        clr,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        fault,
    output logic        err_valid,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          err_valid_q, err_valid_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic [AW-1:0] acc_idx;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wword;
    logic [AW-1:0] ram_waddr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_word;

    assign busy      = (state_q == CLEAR);
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    mem_access_align #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .AW        (AW)
    ) u_align (
        .rd       (rd),
        .wr       (wr),
        .busy     (busy),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .ram_word (ram_word),
        .word_idx (acc_idx),
        .be       (acc_be),
        .wword    (acc_wword),
        .fault    (fault),
        .rdata    (rdata)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        ram_be      = 4'b0000;
        ram_waddr   = acc_idx;
        ram_wdata   = acc_wword;
        case (state_q)
            CLEAR: begin
                ram_be    = 4'b1111;
                ram_waddr = idx_q;
                ram_wdata = 32'h0;
                if (clr) begin
                    idx_d = '0;
                end else if (idx_q == AW'(DEPTH - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                // A clear request outranks any store or fault in the same cycle.
                if (clr) begin
                    state_d     = CLEAR;
                    idx_d       = '0;
                    err_valid_d = 1'b0;
                    err_addr_d  = 32'h0;
                end else begin
                    ram_be = acc_be;
                    if (fault && !err_valid_q) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = addr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            idx_q       <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // One byte-wide array per lane gives per-lane write enables on a shared address.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            always_ff @(posedge clk) begin
                if (ram_be[gi]) begin
                    ram[ram_waddr] <= ram_wdata[8*gi +: 8];
                end
            end
            assign ram_word[8*gi +: 8] = ram[acc_idx];
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: reset/clear timing, sub-word access,
// faults and the error latch, and a second instance with a non-zero base window.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        rd, wr, sign_ext, clr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, err_addr, rdata_b, err_addr_b;
    logic        busy, fault, err_valid, busy_b, fault_b, err_valid_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt;

    data_mem_ctrl #(.DEPTH(128), .BASE_ADDR(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .clr(clr), .rdata(rdata), .busy(busy), .fault(fault),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    data_mem_ctrl #(.DEPTH(128), .BASE_ADDR(32'h1000_0000)) u_dut_b (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .clr(clr), .rdata(rdata_b), .busy(busy_b), .fault(fault_b),
        .err_valid(err_valid_b), .err_addr(err_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Load through one instance: rdata and fault sampled mid-cycle.
    task automatic ld(input string tag, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] exp, input logic exp_f,
                      input logic on_b);
        rd = 1'b1; size = sz; sign_ext = sx; addr = a;
        @(negedge clk);
        if (on_b) begin
            check(tag, rdata_b, exp);
            check({tag, "_fault"}, {31'b0, fault_b}, {31'b0, exp_f});
        end else begin
            check(tag, rdata, exp);
            check({tag, "_fault"}, {31'b0, fault}, {31'b0, exp_f});
        end
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_f, input logic on_b);
        wr = 1'b1; size = sz; addr = a; wdata = d;
        @(negedge clk);
        check(tag, {31'b0, on_b ? fault_b : fault}, {31'b0, exp_f});
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
    endtask

    initial begin
        reset = 1'b0; rd = 1'b1; wr = 1'b0; clr = 1'b0; sign_ext = 1'b0;
        size = SZ_WORD; addr = 32'h6; wdata = 32'h0;

        // Values held during reset, with a would-be faulting load applied
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_err_valid", {31'b0, err_valid}, 32'd0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        rd = 1'b0;
        reset = 1'b1;
        wait_idle(cnt);
        check("rst_busy_cycles", cnt, 32'd128);

        ld("lw_0x0", SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ld("lw_0x1fc", SZ_WORD, 1'b0, 32'h1FC, 32'h0, 1'b0, 1'b0);
        check("post_rst_err_valid", {31'b0, err_valid}, 32'd0);

        // Sub-word stores and extended loads
        st("sw_0x10", SZ_WORD, 32'h10, 32'h1122_3344, 1'b0, 1'b0);
        st("sb_0x11", SZ_BYTE, 32'h11, 32'h0000_00AA, 1'b0, 1'b0);
        st("sh_0x12", SZ_HALF, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0);
        ld("lw_0x10", SZ_WORD, 1'b1, 32'h10, 32'hBEEF_AA44, 1'b0, 1'b0);
        ld("lb_0x11", SZ_BYTE, 1'b1, 32'h11, 32'hFFFF_FFAA, 1'b0, 1'b0);
        ld("lbu_0x11", SZ_BYTE, 1'b0, 32'h11, 32'h0000_00AA, 1'b0, 1'b0);
        ld("lh_0x12", SZ_HALF, 1'b1, 32'h12, 32'hFFFF_BEEF, 1'b0, 1'b0);
        ld("lhu_0x12", SZ_HALF, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0);
        ld("lb_0x10", SZ_BYTE, 1'b1, 32'h10, 32'h0000_0044, 1'b0, 1'b0);

        // Faults and the sticky error latch
        ld("lw_0x6", SZ_WORD, 1'b0, 32'h6, 32'h0, 1'b1, 1'b0);
        check("err_valid_set", {31'b0, err_valid}, 32'd1);
        check("err_addr_0x6", err_addr, 32'h6);
        st("sh_0x201", SZ_HALF, 32'h201, 32'h0000_FFFF, 1'b1, 1'b0);
        st("sw_0x200", SZ_WORD, 32'h200, 32'hFFFF_FFFF, 1'b1, 1'b0);
        ld("lw_0x0_kept", SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("err_addr_kept", err_addr, 32'h6);
        ld("lsz11_0x20", 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);

        // Read-before-write on a simultaneous rd/wr
        rd = 1'b1; wr = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rbw_old", rdata, 32'h0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        ld("rbw_new", SZ_WORD, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Base-window instance
        st("b_sw_4", SZ_WORD, 32'h1000_0004, 32'h5, 1'b0, 1'b1);
        ld("b_lw_4", SZ_WORD, 1'b0, 32'h1000_0004, 32'h5, 1'b0, 1'b1);
        ld("b_lw_low", SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1);

        // Clear pulse with a same-cycle store: clear wins, rdata shows old data
        clr = 1'b1; wr = 1'b1; rd = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'h1234;
        @(negedge clk);
        check("clr_rdata_pre", rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        clr = 1'b0; wr = 1'b0; rd = 1'b0;
        check("clr_busy_rise", {31'b0, busy}, 32'd1);
        wait_idle(cnt);
        check("clr_busy_cycles", cnt, 32'd128);
        ld("clr_lw_0x20", SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
        ld("clr_lw_0x10", SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        check("clr_err_valid", {31'b0, err_valid}, 32'd0);
        check("clr_err_addr", err_addr, 32'h0);

        // Reset at idx 50 of a clear restarts a full clear
        st("sw_0x1fc", SZ_WORD, 32'h1FC, 32'hDEAD_BEEF, 1'b0, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("midclr_rst_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        wait_idle(cnt);
        check("midclr_busy_cycles", cnt, 32'd128);
        ld("midclr_lw_0x1fc", SZ_WORD, 1'b0, 32'h1FC, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the pipeline CPU's MEM stage. It extends the word-only data RAM with byte, halfword and word loads/stores, sign or zero extension, a base-address window, and alignment/range fault detection with a sticky error-address latch. Zeroing after reset, or on a software clear request, is done by a sequencer that walks one word per cycle and holds `busy` high; the pipeline stalls MEM on `busy`, so the RAM stays synthesisable as a single-port array.

## Interface
Parameters:
- `DEPTH`, 128: number of 32-bit words; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH.
- `AW`, $clog2(DEPTH): word-index width (derived, not overridden).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `rd` input 1: load request this cycle.
- `wr` input 1: store request this cycle.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `sign_ext` input 1: 1 sign-extends byte/half loads, 0 zero-extends.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `clr` input 1: one-cycle pulse that starts a full clear.
- `rdata` output 32: load data (combinational).
- `busy` output 1: clear sequence in progress.
- `fault` output 1: current rd/wr access is illegal (combinational).
- `err_valid` output 1: sticky, a fault has occurred since the last clear.
- `err_addr` output 32: address of the first fault since the last clear.

## Operation
- Hit: `addr - BASE_ADDR < 4*DEPTH` (unsigned). Word index = `(addr - BASE_ADDR)[AW+1:2]`; byte lane = `addr[1:0]`.
- Illegal access, when `rd` or `wr` is high with `!busy`: miss, or `size==11`, or half with `addr[0]==1`, or word with `addr[1:0]!=0`. Then `fault=1`, the write is suppressed and `rdata=0`.
- Store, when `wr & !busy & !fault`: a byte writes lane `addr[1:0]`; a half writes lanes {1,0} or {3,2}; a word writes all four. Unselected lanes are kept, using per-lane byte enables.
- Load, when `rd & !busy & !fault`: extracts the selected lane(s), then extends per `sign_ext`. Word loads ignore `sign_ext`. Otherwise `rdata=0`.
- `rd & wr` together on the same address: `rdata` returns the old contents (read before write).
- Faults latch: on the first faulting cycle with `err_valid==0`, the block sets `err_valid` and captures `err_addr<=addr`. Later faults do not overwrite it.
- FSM has two states, CLEAR and IDLE:
  - Async reset: state=CLEAR, idx=0, `err_valid=0`, `err_addr=0`.
  - CLEAR: writes RAM[idx]=0 each cycle and increments idx. When idx==DEPTH-1, it writes, then goes to IDLE.
  - IDLE: `clr=1` → CLEAR with idx=0, `err_valid<=0`, `err_addr<=0`.
  - `clr` during CLEAR restarts idx at 0.
- `busy = (state==CLEAR)`. While busy, `rd`/`wr` are ignored: no write, `rdata=0`, `fault=0`.
- Simultaneous `clr` and `wr` in IDLE: the clear wins and the write is dropped. `rdata` for that cycle still reflects the pre-clear contents.

## Timing
- Values during reset: `busy=1`, `err_valid=0`, `err_addr=0`, `rdata=0`, `fault=0`.
- After `reset` deasserts: `busy` stays high for exactly DEPTH rising edges, then falls. The first legal access is on the next cycle.
- `clr` sampled high in IDLE: `busy` rises after that edge and stays high for DEPTH cycles.
- Store: written at the rising edge; a load of the same address on the next cycle sees the new data.
- Load: zero-cycle combinational path from `addr`/`rd`/`size`/`sign_ext` to `rdata`.
- `fault`: combinational, same cycle. `err_*`: updated at the edge ending the faulting cycle.
- Reset asserted mid-clear or mid-store: the FSM returns to CLEAR at idx=0 immediately. A store in flight is not guaranteed to persist, which is irrelevant because the RAM is re-zeroed.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `CLEAR`/`IDLE`;
  - function `lane_be(size, addr[1:0])` returning a 4-bit byte enable;
  - function `load_extract(word, size, lane, sign_ext)`.
- One sub-module, `mem_access_align`: purely combinational. Computes the byte enables, the shifted write word and the fault flag, and extracts and extends load data. The top module holds the RAM array, the clear FSM and the error latch.

## Test plan
- Reset release, DEPTH=128: `busy` high for 128 cycles; then a word load at each of 0x0, 0x1FC returns 0; `err_valid=0`.
- Sub-word stores: sw 0x11223344 @0x10; sb 0xAA @0x11; sh 0xBEEF @0x12.
  - lw @0x10 → 0xBEEFAA44.
  - lb signed @0x11 → 0xFFFFFFAA.
  - lbu @0x11 → 0x000000AA.
  - lh signed @0x12 → 0xFFFFBEEF.
- Faults:
  - lw @0x6 → `fault=1`, `rdata=0`, `err_addr=0x6`.
  - sh @0x201 (miss and misaligned), then sw @0x200 → memory unchanged; `err_addr` stays 0x6.
- Base window, BASE_ADDR=0x1000_0000: sw 0x5 @0x1000_0004, then lw → 0x5; lw @0x4 → fault.
- Clear: pulse `clr` with `wr` of 0x1234 @0x20 in the same cycle → write dropped, `busy` for 128 cycles; lw @0x20 → 0; `err_valid` cleared.
- Reset asserted at idx=50 of a clear, then released → a full 128-cycle clear restarts and all words read 0.
